// File: rtl/exec_sequencer_pkg.sv
// exec_sequencer_pkg: shared widths, delay sentinel, watchdog limit and state encoding
package exec_sequencer_pkg;
    localparam int OPR_W = 5;
    localparam int DLY_W = 8;
    localparam int TMO_W = 12;
    localparam logic [DLY_W-1:0] DLY_WAIT = 8'd255;
    // Last WAIT cycle index (0-based) before the watchdog fires: 4095 cycles in WAIT
    localparam logic [TMO_W-1:0] TMO_LAST = 12'd4094;
    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_WAIT, S_WB} state_e;
endpackage

// File: rtl/exec_sequencer_dly_cnt.sv
// exec_sequencer_dly_cnt: loadable delay down-counter with zero flag
module exec_sequencer_dly_cnt
    import exec_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DLY_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [DLY_W-1:0] cnt_q, cnt_d;
    // Load has priority; decrement saturates at zero
    always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - DLY_W'(1) : cnt_q;
    // Counter register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    assign zero = (cnt_q == '0);
endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: times instruction write-back by fixed delay or ALU completion, with flush and watchdog
module exec_sequencer
    import exec_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_vld,
    input  logic [OPR_W-1:0] opr_typ_sel,
    input  logic             src_dst_delay_sel,
    input  logic [DLY_W-1:0] src_dst_delay,
    input  logic             alu_done,
    input  logic             flush,
    output logic             issue_rdy,
    output logic             busy,
    output logic             wb_en,
    output logic [OPR_W-1:0] wb_opr,
    output logic             flushed,
    output logic             tmo_err
);
    state_e           state_q, state_d;
    logic [OPR_W-1:0] opr_q, opr_d, wb_opr_q, wb_opr_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             wb_en_q, wb_en_d, flushed_q, flushed_d, tmo_err_q, tmo_err_d;
    logic             accept, load, dec, zero;
    logic [DLY_W-1:0] load_val;

    // WB is entered on the edge that ends cycle N-1, so COUNT holds N-2 down to 0; N<=1 skips COUNT
    assign load_val = (src_dst_delay <= DLY_W'(1)) ? '0 : src_dst_delay - DLY_W'(2);

    exec_sequencer_dly_cnt u_dly_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .dec      (dec),
        .zero     (zero)
    );

    // Next-state and registered-output logic; flush beats alu_done, alu_done beats watchdog
    always_comb begin
        state_d   = state_q;
        opr_d     = opr_q;
        tmo_d     = '0;
        tmo_err_d = tmo_err_q;
        flushed_d = 1'b0;
        load      = 1'b0;
        dec       = 1'b0;
        accept    = issue_vld && src_dst_delay_sel && !flush;
        case (state_q)
            S_IDLE: if (accept) begin
                opr_d   = opr_typ_sel;
                load    = 1'b1;
                state_d = (src_dst_delay == DLY_WAIT) ? S_WAIT :
                          (src_dst_delay <= DLY_W'(1)) ? S_WB : S_COUNT;
            end
            S_COUNT: begin
                dec = 1'b1;
                if (flush) begin
                    state_d   = S_IDLE;
                    flushed_d = 1'b1;
                end else if (zero) state_d = S_WB;
            end
            S_WAIT: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (flush) begin
                    state_d   = S_IDLE;
                    flushed_d = 1'b1;
                end else if (alu_done) state_d = S_WB;
                else if (tmo_q == TMO_LAST) begin
                    state_d   = S_IDLE;
                    tmo_err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        wb_en_d  = (state_d == S_WB);
        wb_opr_d = wb_en_d ? opr_d : wb_opr_q;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q   <= S_IDLE;
            opr_q     <= '0;
            wb_opr_q  <= '0;
            tmo_q     <= '0;
            wb_en_q   <= 1'b0;
            flushed_q <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opr_q     <= opr_d;
            wb_opr_q  <= wb_opr_d;
            tmo_q     <= tmo_d;
            wb_en_q   <= wb_en_d;
            flushed_q <= flushed_d;
            tmo_err_q <= tmo_err_d;
        end

    assign issue_rdy = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign wb_en     = wb_en_q;
    assign wb_opr    = wb_opr_q;
    assign flushed   = flushed_q;
    assign tmo_err   = tmo_err_q;
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed stimulus with a scoreboard of expected write-back and flush pulses
module tb_exec_sequencer;
    logic       clk, rst_n, issue_vld, src_dst_delay_sel, alu_done, flush;
    logic [4:0] opr_typ_sel;
    logic [7:0] src_dst_delay;
    logic       issue_rdy, busy, wb_en, flushed, tmo_err;
    logic [4:0] wb_opr;

    typedef struct {int cyc; bit wb; logic [4:0] opr;} ev_t;
    ev_t exp_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    exec_sequencer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .issue_vld         (issue_vld),
        .opr_typ_sel       (opr_typ_sel),
        .src_dst_delay_sel (src_dst_delay_sel),
        .src_dst_delay     (src_dst_delay),
        .alu_done          (alu_done),
        .flush             (flush),
        .issue_rdy         (issue_rdy),
        .busy              (busy),
        .wb_en             (wb_en),
        .wb_opr            (wb_opr),
        .flushed           (flushed),
        .tmo_err           (tmo_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push_ev(input int c, input bit wb, input logic [4:0] opr);
        exp_q.push_back('{cyc: c, wb: wb, opr: opr});
    endtask

    // Drive one instruction for one cycle; optionally expect its timed write-back
    task automatic issue(input logic [4:0] opr, input bit sel, input logic [7:0] dly, input bit expect_wb);
        issue_vld = 1; opr_typ_sel = opr; src_dst_delay_sel = sel; src_dst_delay = dly;
        if (expect_wb) push_ev(cyc + ((dly == 0) ? 1 : int'(dly)), 1, opr);
        step();
        issue_vld = 0; src_dst_delay_sel = 0;
    endtask

    // Monitor: every wb_en or flushed pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && (wb_en || flushed)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse at cycle %0d: wb_en=%0b flushed=%0b wb_opr=%0d, none expected", cyc, wb_en, flushed, wb_opr);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || wb_en !== e.wb || flushed !== !e.wb || (e.wb && wb_opr !== e.opr)) begin
                    errors++;
                    $display("FAIL pulse at cycle %0d: wb_en=%0b flushed=%0b wb_opr=%0d, expected cycle %0d wb=%0b opr=%0d",
                             cyc, wb_en, flushed, wb_opr, e.cyc, e.wb, e.opr);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        issue_vld = 0; opr_typ_sel = 0; src_dst_delay_sel = 0; src_dst_delay = 0;
        alu_done = 0; flush = 0; rst_n = 0;
        step(); step();
        chk("rst_issue_rdy", issue_rdy, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_flushed", flushed, 0);
        chk("rst_tmo_err", tmo_err, 0);
        chk("rst_wb_opr", wb_opr, 0);
        rst_n = 1;
        step();
        // ADD delay 4: wb at +4, ready at +5; issue and alu_done during COUNT are ignored
        issue(2, 1, 4, 1);
        chk("add_busy", busy, 1);
        chk("add_rdy_low", issue_rdy, 0);
        issue_vld = 1; src_dst_delay_sel = 1; src_dst_delay = 1; opr_typ_sel = 9; alu_done = 1;
        step(); step();
        issue_vld = 0; src_dst_delay_sel = 0; alu_done = 0;
        step();
        chk("add_rdy_in_wb", issue_rdy, 0);
        step();
        chk("add_rdy", issue_rdy, 1);
        // MUL wait for ALU: alu_done at +40 -> wb at +41
        issue(5, 1, 255, 0);
        push_ev(cyc + 40, 1, 5);
        chk("mul_busy_first", busy, 1);
        repeat (39) step();
        alu_done = 1;
        step();
        alu_done = 0;
        chk("mul_busy_last", busy, 1);
        step();
        chk("mul_rdy", issue_rdy, 1);
        // JRE delay 7 with flush at +3 -> flushed at +4, idle at +4
        issue(6, 1, 7, 0);
        push_ev(cyc + 3, 0, 0);
        step(); step();
        flush = 1;
        step();
        flush = 0;
        chk("jre_idle", issue_rdy, 1);
        repeat (10) step();
        // flush and alu_done together in WAIT: flush wins
        issue(7, 1, 255, 0);
        push_ev(cyc + 5, 0, 0);
        repeat (4) step();
        flush = 1; alu_done = 1;
        step();
        flush = 0; alu_done = 0;
        repeat (5) step();
        // flush during WB does not cancel the write-back
        issue(3, 1, 2, 1);
        step();
        flush = 1;
        step();
        flush = 0;
        chk("wbflush_rdy", issue_rdy, 1);
        // flush in IDLE blocks the accept
        issue_vld = 1; src_dst_delay_sel = 1; src_dst_delay = 1; opr_typ_sel = 4; flush = 1;
        step();
        issue_vld = 0; src_dst_delay_sel = 0; flush = 0;
        repeat (3) step();
        chk("idleflush_rdy", issue_rdy, 1);
        chk("wb_opr_hold", wb_opr, 3);
        // delay 0, back-to-back delay 1, NOP, delay 1
        issue(10, 1, 0, 1);
        step();
        issue(11, 1, 1, 1);
        step();
        issue(12, 0, 1, 0);
        issue(13, 1, 1, 1);
        repeat (3) step();
        chk("b2b_wb_opr", wb_opr, 13);
        // reset during COUNT aborts silently
        issue(14, 1, 10, 0);
        step(); step();
        rst_n = 0;
        #1;
        chk("mid_rst_rdy", issue_rdy, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wb_opr", wb_opr, 0);
        chk("mid_rst_wb_en", wb_en, 0);
        step();
        rst_n = 1;
        repeat (15) step();
        // DIV waiting forever: watchdog after 4095 WAIT cycles
        issue(8, 1, 255, 0);
        repeat (4094) step();
        chk("tmo_not_yet", tmo_err, 0);
        chk("tmo_busy", busy, 1);
        step();
        chk("tmo_set", tmo_err, 1);
        chk("tmo_idle", issue_rdy, 1);
        issue(2, 1, 3, 1);
        repeat (4) step();
        chk("tmo_sticky", tmo_err, 1);
        rst_n = 0;
        #1;
        chk("tmo_rst_clear", tmo_err, 0);
        step();
        rst_n = 1;
        repeat (3) step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameters (from define.v): OPR_W 5, meaning opcode width; DLY_W 8, meaning delay width; DLY_WAIT 8'd255, meaning sentinel for "wait for ALU completion"; TMO_W 12, meaning watchdog width.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 issue_vld  input  1  decoded instruction present this cycle.
REQ-005 opr_typ_sel  input  OPR_W  decoded operation code.
REQ-006 src_dst_delay_sel  input  1  instruction carries a timed delay; 0 means NOP.
REQ-007 src_dst_delay  input  DLY_W  cycles until write-back, or DLY_WAIT.
REQ-008 alu_done  input  1  ALU completion pulse for long operations.
REQ-009 flush  input  1  jump taken; abort the in-flight operation.
REQ-010 issue_rdy  output  1  sequencer is idle and accepts an instruction.
REQ-011 busy  output  1  operation in flight, used to stall fetch.
REQ-012 wb_en  output  1  one-cycle write-back strobe.
REQ-013 wb_opr  output  OPR_W  opcode of the operation being written back.
REQ-014 flushed  output  1  one-cycle pulse when an in-flight operation is aborted.
REQ-015 tmo_err  output  1  sticky watchdog error.

Function
REQ-016 States SHALL be IDLE, COUNT, WAIT, WB.
REQ-017 Accept SHALL occur when state is IDLE, issue_vld is 1, src_dst_delay_sel is 1 and flush is 0; opr_typ_sel is latched on accept.
REQ-018 issue_vld with src_dst_delay_sel 0 SHALL be a NOP: the sequencer stays in IDLE and produces no wb_en.
REQ-019 issue_vld SHALL be ignored outside IDLE; the upstream stage holds the instruction until issue_rdy is 1.
REQ-020 Delay N in 1..254 SHALL give IDLE->COUNT on accept, with wb_en high exactly N cycles after the accept cycle; N=0 SHALL behave as N=1.
REQ-021 Delay DLY_WAIT SHALL give IDLE->WAIT; WAIT->WB on the cycle after alu_done is sampled 1; alu_done is sampled from the cycle after accept onward.
REQ-022 alu_done SHALL be ignored in IDLE, COUNT and WB.
REQ-023 WB SHALL last one cycle with wb_en=1 and wb_opr=latched opcode, then go to IDLE; back-to-back accept is possible on the following cycle.
REQ-024 issue_rdy SHALL be 1 only in IDLE; busy SHALL be 1 in COUNT, WAIT and WB.
REQ-025 flush in COUNT or WAIT SHALL force IDLE on the next edge, suppress wb_en and pulse flushed for one cycle.
REQ-026 flush in WB SHALL NOT suppress wb_en (write committed); flushed stays 0.
REQ-027 flush in IDLE SHALL block accept that cycle and SHALL have no other effect.
REQ-028 flush and alu_done in the same WAIT cycle: flush SHALL win.
REQ-029 Watchdog: a TMO_W-bit counter SHALL run in WAIT; at 4095 cycles without alu_done it SHALL set tmo_err, return to IDLE and produce no wb_en.
REQ-030 tmo_err SHALL be cleared only by reset.
REQ-031 wb_opr SHALL hold its last value outside WB.

Reset
REQ-032 While rst_n=0 the state SHALL be IDLE, with counters 0, wb_en/flushed/tmo_err/busy 0, wb_opr 0 and issue_rdy 1.
REQ-033 Reset asserted mid-operation SHALL abort with no wb_en or flushed pulse after release.

Structure
REQ-034 OPR_W, DLY_W, DLY_WAIT, TMO_W and the state encodings SHALL reside in shared define.v.
REQ-035 The delay down-counter SHALL be one sub-module, dly_cnt: loadable, with decrement and zero flag.
REQ-036 All outputs except issue_rdy and busy SHALL be registered.

Verification
REQ-037 Accept ADD with delay 4 at cycle 0 -> wb_en=1 and wb_opr=2 at cycle 4 only; issue_rdy=1 at cycle 5.
REQ-038 Accept MUL with delay 255, alu_done at cycle 40 -> wb_en at cycle 41, busy 1 for cycles 1..41.
REQ-039 Accept JRE with delay 7, flush at cycle 3 -> flushed at cycle 4, no wb_en, IDLE at cycle 4.
REQ-040 Accept DIV with delay 255, no alu_done -> tmo_err=1 after 4095 WAIT cycles, IDLE, no wb_en.
REQ-041 Delay 0, then back-to-back delay 1 instructions -> wb_en at cycles 1 and 3; NOP (sel=0) in between -> no wb_en.
REQ-042 rst_n low during COUNT -> all outputs at reset values, no wb_en after release.
